// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: state encodings, handshake
// constants and the magnitude helper used when latching signed operands.
package div_pkg;

    localparam logic RstEnable         = 1'b1;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic [31:0] ZeroWord   = 32'h0000_0000;
    localparam int DoubleRegBus        = 64;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    // Two's-complement magnitude when neg is set, otherwise the value as-is.
    // 0x80000000 maps onto itself, which gives the wrap-around behaviour for
    // the most negative dividend.
    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div.sv
// Radix-2 restoring divider, 32 iterations, signed or unsigned.
// Result is {remainder, quotient}; remainder takes the sign of the dividend.
module div
    import div_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    signed_div_i,
    input  logic [31:0]             opdata1_i,
    input  logic [31:0]             opdata2_i,
    input  logic                    start_i,
    input  logic                    annul_i,
    output logic [DoubleRegBus-1:0] result_o,
    output logic                    ready_o
);

    div_state_e              state_q, state_d;
    logic [5:0]              cnt_q, cnt_d;
    logic [64:0]             work_q, work_d;
    logic [31:0]             divisor_q, divisor_d;
    logic                    neg_quot_q, neg_quot_d;
    logic                    neg_rem_q, neg_rem_d;
    logic [DoubleRegBus-1:0] result_q, result_d;
    logic                    ready_q, ready_d;

    logic                    op1_neg;
    logic                    op2_neg;
    logic [32:0]             diff;
    logic [31:0]             quot_mag;
    logic [31:0]             rem_mag;

    // Next-state, datapath and output computation for the divider FSM.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        divisor_d  = divisor_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;

        op1_neg  = signed_div_i & opdata1_i[31];
        op2_neg  = signed_div_i & opdata2_i[31];
        // Trial subtraction of the divisor from the current partial remainder
        // window; bit 32 set means the divisor did not fit.
        diff     = {1'b0, work_q[63:32]} - {1'b0, divisor_q};
        quot_mag = work_q[31:0];
        rem_mag  = work_q[64:33];

        case (state_q)
            DivFree: begin
                ready_d  = DivResultNotReady;
                result_d = {ZeroWord, ZeroWord};
                // Annul has priority over a simultaneous start request.
                if (start_i == DivStart && annul_i == 1'b0) begin
                    state_d    = (opdata2_i == ZeroWord) ? DivByZero : DivOn;
                    cnt_d      = 6'd0;
                    divisor_d  = magnitude(opdata2_i, op2_neg);
                    work_d     = {ZeroWord, magnitude(opdata1_i, op1_neg), 1'b0};
                    neg_quot_d = op1_neg ^ op2_neg;
                    neg_rem_d  = op1_neg;
                end
            end

            DivByZero: begin
                result_d = {ZeroWord, ZeroWord};
                if (annul_i) begin
                    state_d = DivFree;
                    ready_d = DivResultNotReady;
                end else begin
                    state_d = DivEnd;
                    ready_d = DivResultReady;
                end
            end

            DivOn: begin
                if (annul_i) begin
                    state_d  = DivFree;
                    ready_d  = DivResultNotReady;
                    result_d = {ZeroWord, ZeroWord};
                end else if (cnt_q != 6'd32) begin
                    work_d = diff[32] ? {work_q[63:0], 1'b0}
                                      : {diff[31:0], work_q[31:0], 1'b1};
                    cnt_d  = cnt_q + 6'd1;
                end else begin
                    result_d = {magnitude(rem_mag, neg_rem_q),
                                magnitude(quot_mag, neg_quot_q)};
                    ready_d  = DivResultReady;
                    state_d  = DivEnd;
                end
            end

            DivEnd: begin
                // Result is held for as long as the requester keeps start high.
                if (start_i == DivStop) begin
                    state_d  = DivFree;
                    ready_d  = DivResultNotReady;
                    result_d = {ZeroWord, ZeroWord};
                end
            end

            default: begin
                state_d  = DivFree;
                ready_d  = DivResultNotReady;
                result_d = {ZeroWord, ZeroWord};
            end
        endcase
    end

    // State register with synchronous reset that clears every working register.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q    <= DivFree;
            cnt_q      <= 6'd0;
            work_q     <= 65'd0;
            divisor_q  <= ZeroWord;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= {ZeroWord, ZeroWord};
            ready_q    <= DivResultNotReady;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            divisor_q  <= divisor_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// Directed bench for the divider: expected results go into a queue when a
// division is issued, a monitor pops and compares on each rising ready_o.
module tb_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    logic [63:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic        mon_ready_prev = 1'b0;
    logic [63:0] mon_exp;

    always #5 clk = ~clk;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Scoreboard monitor: one compare per result presented by the DUT.
    initial begin
        forever begin
            @(negedge clk);
            if (ready_o === 1'b1 && mon_ready_prev !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL scoreboard: unexpected result %h, expected none", result_o);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("scoreboard", result_o, mon_exp);
                end
            end
            mon_ready_prev = ready_o;
        end
    end

    // Full transaction: issue, scramble operands after accept, measure latency,
    // check hold while start stays high, then release and check clear-down.
    task automatic run_div(input string name, input logic sg, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
        bit got;
        int lat;
        @(negedge clk);
        signed_div_i = sg;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        exp_q.push_back(exp);
        $display("issue %s: signed=%0b %h / %h", name, sg, a, b);
        @(posedge clk);
        #1;
        opdata1_i    = ~a;
        opdata2_i    = b ^ 32'h5A5A_0001;
        signed_div_i = ~sg;
        got = 1'b0;
        lat = -1;
        for (int i = 0; i <= 64 && !got; i++) begin
            @(negedge clk);
            if (ready_o === 1'b1) begin
                got = 1'b1;
                lat = i;
            end
        end
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check({name, "_hold_ready"}, {63'd0, ready_o}, 64'd1);
            check({name, "_hold_result"}, result_o, exp);
        end
        start_i = 1'b0;
        @(negedge clk);
        check({name, "_release_ready"}, {63'd0, ready_o}, 64'd0);
        check({name, "_release_result"}, result_o, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rise_cnt;
        bit got;
        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        annul_i      = 1'b0;

        // Start requested during reset must be ignored.
        repeat (3) begin
            @(negedge clk);
            check("reset_ready", {63'd0, ready_o}, 64'd0);
            check("reset_result", result_o, 64'd0);
        end
        rst     = 1'b0;
        start_i = 1'b0;

        run_div("u100_7",     1'b0, 32'd100,       32'd7,         64'h00000002_0000000E, 33);
        run_div("s-7_2",      1'b1, 32'hFFFFFFF9,  32'h00000002,  64'hFFFFFFFF_FFFFFFFD, 33);
        run_div("s7_-2",      1'b1, 32'h00000007,  32'hFFFFFFFE,  64'h00000001_FFFFFFFD, 33);
        run_div("s-8_-3",     1'b1, 32'hFFFFFFF8,  32'hFFFFFFFD,  64'hFFFFFFFE_00000002, 33);
        run_div("u5_0",       1'b0, 32'd5,         32'd0,         64'h00000000_00000000, 1);
        run_div("s0_0",       1'b1, 32'd0,         32'd0,         64'h00000000_00000000, 1);
        run_div("uFFFF_1",    1'b0, 32'hFFFFFFFF,  32'h00000001,  64'h00000000_FFFFFFFF, 33);
        run_div("smin_-1",    1'b1, 32'h80000000,  32'hFFFFFFFF,  64'h00000000_80000000, 33);
        run_div("u8000_FFFF", 1'b0, 32'h80000000,  32'hFFFFFFFF,  64'h80000000_00000000, 33);
        run_div("uFFFF_16",   1'b0, 32'hFFFFFFFF,  32'h00000010,  64'h0000000F_0FFFFFFF, 33);
        run_div("u3_5",       1'b0, 32'd3,         32'd5,         64'h00000003_00000000, 33);

        // Annul at E10, start held high with annul: no result, no restart.
        @(negedge clk);
        $display("issue annul: 100 / 7 annulled at E10");
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("annul_ready", {63'd0, ready_o}, 64'd0);
            check("annul_result", result_o, 64'd0);
        end
        start_i = 1'b0;
        annul_i = 1'b0;
        rise_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o === 1'b1) rise_cnt++;
        end
        check("annul_no_result", 64'(rise_cnt), 64'd0);

        run_div("u9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33);

        // Reset mid-division at E20.
        @(negedge clk);
        $display("issue rst_mid: 100 / 7 reset at E20");
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        @(posedge clk);
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("rst_mid_ready", {63'd0, ready_o}, 64'd0);
            check("rst_mid_result", result_o, 64'd0);
        end
        rst     = 1'b0;
        start_i = 1'b0;
        rise_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o === 1'b1) rise_cnt++;
        end
        check("rst_mid_no_result", 64'(rise_cnt), 64'd0);

        run_div("u100_7_again", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);

        // Reset while a finished result is being held clears it at once.
        @(negedge clk);
        $display("issue rst_end: 45 / 6 reset while held");
        signed_div_i = 1'b0;
        opdata1_i    = 32'd45;
        opdata2_i    = 32'd6;
        start_i      = 1'b1;
        exp_q.push_back(64'h00000003_00000007);
        got = 1'b0;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            if (ready_o === 1'b1) got = 1'b1;
        end
        check("rst_end_reached", {63'd0, got}, 64'd1);
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("rst_end_ready", {63'd0, ready_o}, 64'd0);
            check("rst_end_result", result_o, 64'd0);
        end
        rst     = 1'b0;
        start_i = 1'b0;

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
